// File: rtl/seg_scan_ctrl.sv
// Scan controller for a 4-digit common-anode 7-segment display: double-buffered
// load port, per-digit dwell with blanking gap, and 16-level PWM brightness.
module seg_scan_ctrl #(
  parameter int unsigned DWELL_LOG2 = 17,
  parameter int unsigned BLANK_CYC  = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_digits,
  input  logic [3:0]  load_dp,
  input  logic [3:0]  brightness,
  output logic [6:0]  cathode,
  output logic        dp_n,
  output logic [3:0]  anode,
  output logic        frame_done
);

  localparam int unsigned BLANK_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam int unsigned CNT_W   = (DWELL_LOG2 > BLANK_W) ? DWELL_LOG2 : BLANK_W;
  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'((64'd1 << DWELL_LOG2) - 64'd1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [6:0]       SEG_OFF    = 7'b1111111;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } state_t;

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  dp;
  } disp_buf_t;

  localparam disp_buf_t BUF_BLANK = '{digits: 16'hFFFF, dp: 4'h0};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  disp_buf_t        active_q, active_d;
  disp_buf_t        shadow_q, shadow_d;
  logic             ready_d;
  logic             boundary_c;
  logic             lit_c;
  logic [3:0]       cur_digit_c;
  logic             cur_dp_c;
  logic [3:0]       anode_d;
  logic [6:0]       cathode_d;
  logic             dp_n_d;

  // Active-low {g,f,e,d,c,b,a}; codes 10..15 blank the digit.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

  // Scan sequencing: ON dwell then BLANK gap, advancing the digit at the end of BLANK.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    idx_d      = idx_q;
    boundary_c = 1'b0;
    case (state_q)
      ST_ON: begin
        if (cnt_q == ON_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
        end
      end
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d    = ST_ON;
          cnt_d      = '0;
          idx_d      = idx_q + 2'd1;
          boundary_c = (idx_q == 2'd3);
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
      end
    endcase
  end

  // Pin drive, registered one stage behind the scan state.
  always_comb begin
    anode_d     = 4'b1111;
    cathode_d   = SEG_OFF;
    dp_n_d      = 1'b1;
    cur_digit_c = 4'(active_q.digits >> {idx_q, 2'b00});
    cur_dp_c    = active_q.dp[idx_q];
    lit_c       = (state_q == ST_ON) && (cnt_q[DWELL_LOG2-1 -: 4] <= brightness);
    if (state_q == ST_ON) begin
      cathode_d = seg_decode(cur_digit_c);
    end
    if (lit_c) begin
      anode_d[idx_q] = 1'b0;
      dp_n_d         = ~cur_dp_c;
    end
  end

  // Shadow/active buffering: copy only at a frame boundary so a frame never tears.
  always_comb begin
    active_d = active_q;
    shadow_d = shadow_q;
    ready_d  = load_ready;
    if (boundary_c && !load_ready) begin
      active_d = shadow_q;
      ready_d  = 1'b1;
    end else if (load_valid && load_ready) begin
      shadow_d.digits = load_digits;
      shadow_d.dp     = load_dp;
      ready_d         = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BLANK;
      cnt_q      <= '0;
      idx_q      <= 2'd0;
      active_q   <= BUF_BLANK;
      shadow_q   <= '0;
      load_ready <= 1'b1;
      anode      <= 4'b1111;
      cathode    <= SEG_OFF;
      dp_n       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      active_q   <= active_d;
      shadow_q   <= shadow_d;
      load_ready <= ready_d;
      anode      <= anode_d;
      cathode    <= cathode_d;
      dp_n       <= dp_n_d;
      frame_done <= boundary_c;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with a short dwell (64 ON + 4 BLANK cycles per digit).
module tb_seg_scan_ctrl;

  localparam int unsigned DWELL_LOG2 = 6;
  localparam int unsigned BLANK_CYC  = 4;
  localparam int unsigned DIGIT_CYC  = 68;
  localparam int unsigned FRAME_CYC  = 272;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] SB = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_digits = 16'h0000;
  logic [3:0]  load_dp = 4'h0;
  logic [3:0]  brightness = 4'hF;
  logic [6:0]  cathode;
  logic        dp_n;
  logic [3:0]  anode;
  logic        frame_done;

  int errors = 0;
  int checks = 0;

  seg_scan_ctrl #(
    .DWELL_LOG2(DWELL_LOG2),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_digits(load_digits),
    .load_dp    (load_dp),
    .brightness (brightness),
    .cathode    (cathode),
    .dp_n       (dp_n),
    .anode      (anode),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Run until frame_done is seen (bounded); checks the cycle count and scan sanity.
  task automatic wait_frame(input string tag, input bit chk_blank, input int exp_n);
    int n = 0;
    bit bad = 1'b0;
    bit seen = 1'b0;
    while (n < 2 * int'(FRAME_CYC) && !seen) begin
      @(posedge clk); #1;
      n++;
      if ($countones(~anode) > 1) bad = 1'b1;
      if (chk_blank && cathode !== SB) bad = 1'b1;
      seen = (frame_done === 1'b1);
    end
    check({tag, "_cycles"}, 32'(n), 32'(exp_n));
    check({tag, "_scan"}, 32'(bad), 32'(0));
  endtask

  // One digit slot: 64 ON samples then 4 BLANK samples.
  task automatic check_digit(input string tag, input int idx, input logic [6:0] exp_cath,
                             input logic exp_dp_n, input int lit);
    int an_bad = 0;
    int seg_bad = 0;
    logic [3:0] one_hot;
    logic [3:0] exp_an;
    one_hot = 4'b0001 << idx;
    for (int t = 0; t < int'(DIGIT_CYC); t++) begin
      @(posedge clk); #1;
      exp_an = (t < lit) ? ~one_hot : 4'b1111;
      if (anode !== exp_an) an_bad++;
      if (t < lit && (cathode !== exp_cath || dp_n !== exp_dp_n)) seg_bad++;
      if (t >= 64 && (cathode !== SB || dp_n !== 1'b1)) seg_bad++;
    end
    check({tag, "_anode"}, 32'(an_bad), 32'(0));
    check({tag, "_seg"}, 32'(seg_bad), 32'(0));
  endtask

  // Whole frame from digit 0; cath = {d3,d2,d1,d0}.
  task automatic check_frame(input string tag, input logic [27:0] cath, input logic [3:0] dp,
                             input int lit);
    for (int i = 0; i < 4; i++) begin
      check_digit($sformatf("%s_d%0d", tag, i), i, cath[i*7 +: 7], ~dp[i], lit);
    end
    check({tag, "_frame_done"}, 32'(frame_done), 32'(1));
  endtask

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_anode", 32'(anode), 32'(4'b1111));
    check("rst_cathode", 32'(cathode), 32'(SB));
    check("rst_dp_n", 32'(dp_n), 32'(1));
    check("rst_frame_done", 32'(frame_done), 32'(0));
    check("rst_ready", 32'(load_ready), 32'(1));

    // Idle: first boundary after BLANK + three digits, then every frame
    @(negedge clk);
    rst_n = 1'b1;
    wait_frame("first_frame", 1'b1, 208);
    wait_frame("second_frame", 1'b1, 272);

    // Load 1234 with dp on digit 2, full brightness
    load_digits = 16'h1234;
    load_dp     = 4'b0100;
    brightness  = 4'd15;
    load_valid  = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
    check("load_ready_drop", 32'(load_ready), 32'(0));
    wait_frame("copy_frame", 1'b1, 271);
    check("ready_after_copy", 32'(load_ready), 32'(1));
    check_frame("f1234_b15", {S1, S2, S3, S4}, 4'b0100, 64);

    // Brightness changes
    brightness = 4'd3;
    check_frame("f1234_b3", {S1, S2, S3, S4}, 4'b0100, 16);
    brightness = 4'd0;
    check_frame("f1234_b0", {S1, S2, S3, S4}, 4'b0100, 4);

    // A accepted, then B held with valid high while shadow is busy
    brightness  = 4'd15;
    load_digits = 16'h0001;
    load_dp     = 4'h0;
    load_valid  = 1'b1;
    @(posedge clk); #1;
    check("a_accepted", 32'(load_ready), 32'(0));
    load_digits = 16'h0002;
    wait_frame("hold_b", 1'b0, 271);
    check("ready_after_a_copy", 32'(load_ready), 32'(1));
    check_digit("fA_d0", 0, S1, 1'b1, 64);
    load_valid = 1'b0;
    check("b_accepted", 32'(load_ready), 32'(0));
    check_digit("fA_d1", 1, S0, 1'b1, 64);
    check_digit("fA_d2", 2, S0, 1'b1, 64);
    check_digit("fA_d3", 3, S0, 1'b1, 64);
    check("fA_frame_done", 32'(frame_done), 32'(1));
    check_frame("fB", {S0, S0, S0, S2}, 4'b0000, 64);
    check("ready_after_b_copy", 32'(load_ready), 32'(1));

    // Load exactly on the boundary cycle: lands in shadow, shown one frame later
    repeat (FRAME_CYC - 1) @(posedge clk);
    #1;
    load_digits = 16'h5678;
    load_dp     = 4'b0001;
    load_valid  = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
    check("bnd_pulse", 32'(frame_done), 32'(1));
    check("bnd_accept", 32'(load_ready), 32'(0));
    check_frame("fB_again", {S0, S0, S0, S2}, 4'b0000, 64);
    check("ready_after_5678_copy", 32'(load_ready), 32'(1));

    // New pending load, then reset mid ON of digit 2
    load_digits = 16'h4321;
    load_dp     = 4'b1111;
    load_valid  = 1'b1;
    check_digit("f5678_d0", 0, S8, 1'b0, 64);
    load_valid = 1'b0;
    check("pending_before_rst", 32'(load_ready), 32'(0));
    check_digit("f5678_d1", 1, S7, 1'b1, 64);
    repeat (20) @(posedge clk);
    #2;
    check("pre_rst_anode", 32'(anode), 32'(4'b1011));
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_anode", 32'(anode), 32'(4'b1111));
    check("async_rst_ready", 32'(load_ready), 32'(1));
    check("async_rst_cathode", 32'(cathode), 32'(SB));
    @(negedge clk);
    rst_n = 1'b1;
    wait_frame("post_rst", 1'b1, 208);
    check("post_rst_ready", 32'(load_ready), 32'(1));
    check_digit("post_rst_d0", 0, SB, 1'b1, 64);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
